// File: rtl/bp_me_wormhole_concentrator_rr.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_wormhole_concentrator_rr
// Purpose  : N-way wormhole concentrator. The upstream path merges num_in_p
//            tile-side links onto one concentrated link. It uses round-robin
//            arbitration, and a packet stays locked to its link until the
//            packet ends. The downstream path routes returning packets to
//            the link named by the header cid. Packets with an out-of-range
//            cid are dropped, and a sticky error flag is raised.
// Ports    : clk_i, reset_n_i (async, active-low)
//            links_v_i / links_data_i / links_ready_and_o   tile -> conc
//            links_v_o / links_data_o / links_ready_and_i   conc -> tile
//            conc_v_o  / conc_data_o  / conc_ready_and_i    concentrated up
//            conc_v_i  / conc_data_i  / conc_ready_and_o    concentrated down
//            err_o                                          sticky bad-cid
// Revision : 1.0 - initial release
// ============================================================================
module bp_me_wormhole_concentrator_rr #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4,
    parameter int cid_width_p  = 4,
    parameter int num_in_p     = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,

    input  logic [num_in_p-1:0]              links_v_i,
    input  logic [num_in_p*flit_width_p-1:0] links_data_i,
    output logic [num_in_p-1:0]              links_ready_and_o,

    output logic [num_in_p-1:0]              links_v_o,
    output logic [num_in_p*flit_width_p-1:0] links_data_o,
    input  logic [num_in_p-1:0]              links_ready_and_i,

    output logic                             conc_v_o,
    output logic [flit_width_p-1:0]          conc_data_o,
    input  logic                             conc_ready_and_i,

    input  logic                             conc_v_i,
    input  logic [flit_width_p-1:0]          conc_data_i,
    output logic                             conc_ready_and_o,

    output logic                             err_o
);

    localparam int PTR_W   = $clog2(num_in_p);
    localparam int LEN_LSB = cord_width_p;
    localparam int CID_LSB = cord_width_p + len_width_p;

    localparam logic [PTR_W-1:0]       LAST_IDX   = PTR_W'(num_in_p - 1);
    localparam logic [PTR_W:0]         NUM_IN_EXT = (PTR_W+1)'(num_in_p);
    localparam logic [cid_width_p:0]   NUM_IN_CID = (cid_width_p+1)'(num_in_p);
    localparam logic [len_width_p-1:0] LEN_ONE    = len_width_p'(1);

    typedef enum logic {
        UP_IDLE = 1'b0,
        UP_BUSY = 1'b1
    } up_state_e;

    typedef enum logic [1:0] {
        DN_IDLE = 2'd0,
        DN_BUSY = 2'd1,
        DN_DROP = 2'd2
    } dn_state_e;

    // ------------------------------------------------------------------
    // Upstream: round-robin arbitration with a wormhole lock
    // ------------------------------------------------------------------
    up_state_e              up_state_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       rr_ptr_d;
    logic [PTR_W-1:0]       lock_q;
    logic [len_width_p-1:0] up_cnt_q;

    logic [PTR_W-1:0]       grant;
    logic                   grant_found;
    logic [PTR_W:0]         scan_sum;
    logic [PTR_W-1:0]       scan_idx;
    logic [PTR_W-1:0]       up_sel;
    logic                   up_hs;
    logic [len_width_p-1:0] up_len;

    // Find the first valid link, starting at rr_ptr and wrapping past the top.
    // If no link is valid, grant keeps the value of rr_ptr. That link's valid
    // is 0, so nothing transfers.
    always_comb begin
        grant       = rr_ptr_q;
        grant_found = 1'b0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int i = 0; i < num_in_p; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            scan_idx = (scan_sum >= NUM_IN_EXT) ? PTR_W'(scan_sum - NUM_IN_EXT)
                                                : scan_sum[PTR_W-1:0];
            if (!grant_found && links_v_i[scan_idx]) begin
                grant_found = 1'b1;
                grant       = scan_idx;
            end
        end
    end

    assign rr_ptr_d    = (grant == LAST_IDX) ? '0 : grant + PTR_W'(1);
    assign up_sel      = (up_state_q == UP_BUSY) ? lock_q : grant;
    assign conc_v_o    = reset_n_i & links_v_i[up_sel];
    assign conc_data_o = links_data_i[int'(up_sel)*flit_width_p +: flit_width_p];
    assign up_hs       = conc_v_o & conc_ready_and_i;
    assign up_len      = conc_data_o[LEN_LSB +: len_width_p];

    // Only the selected link sees conc_ready_and_i. Every other link is held
    // off, so no link can transfer a flit that was not forwarded.
    always_comb begin
        links_ready_and_o = '0;
        if (reset_n_i) begin
            links_ready_and_o[up_sel] = conc_ready_and_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            up_state_q <= UP_IDLE;
            rr_ptr_q   <= '0;
            lock_q     <= '0;
            up_cnt_q   <= '0;
        end else begin
            case (up_state_q)
                UP_IDLE: begin
                    if (up_hs) begin
                        rr_ptr_q <= rr_ptr_d;
                        if (up_len != '0) begin
                            lock_q     <= grant;
                            up_cnt_q   <= up_len;
                            up_state_q <= UP_BUSY;
                        end
                    end
                end
                UP_BUSY: begin
                    if (up_hs) begin
                        up_cnt_q <= up_cnt_q - LEN_ONE;
                        if (up_cnt_q == LEN_ONE) begin
                            up_state_q <= UP_IDLE;
                        end
                    end
                end
                default: up_state_q <= UP_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Downstream: cid demultiplexer with bad-cid drop
    // ------------------------------------------------------------------
    dn_state_e              dn_state_q;
    logic [PTR_W-1:0]       dest_q;
    logic [len_width_p-1:0] dn_cnt_q;
    logic                   err_q;

    logic [cid_width_p-1:0] dn_cid;
    logic                   cid_ok;
    logic                   dn_drop;
    logic [PTR_W-1:0]       dn_dest;
    logic                   dn_hs;
    logic [len_width_p-1:0] dn_len;

    assign dn_cid  = conc_data_i[CID_LSB +: cid_width_p];
    assign dn_len  = conc_data_i[LEN_LSB +: len_width_p];
    assign cid_ok  = ({1'b0, dn_cid} < NUM_IN_CID);
    assign dn_drop = (dn_state_q == DN_DROP) || ((dn_state_q == DN_IDLE) && !cid_ok);
    // In IDLE the header itself names the destination. Truncating the cid is
    // safe because the truncated value is only used when cid < num_in_p.
    assign dn_dest = (dn_state_q == DN_IDLE) ? dn_cid[PTR_W-1:0] : dest_q;

    assign conc_ready_and_o = reset_n_i & (dn_drop | links_ready_and_i[dn_dest]);
    assign dn_hs            = conc_v_i & conc_ready_and_o;
    assign links_data_o     = {num_in_p{conc_data_i}};
    assign err_o            = err_q;

    always_comb begin
        links_v_o = '0;
        if (reset_n_i && !dn_drop) begin
            links_v_o[dn_dest] = conc_v_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dn_state_q <= DN_IDLE;
            dest_q     <= '0;
            dn_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (dn_state_q)
                DN_IDLE: begin
                    if (dn_hs) begin
                        if (!cid_ok) begin
                            err_q <= 1'b1;
                        end
                        if (dn_len != '0) begin
                            dest_q     <= dn_dest;
                            dn_cnt_q   <= dn_len;
                            dn_state_q <= cid_ok ? DN_BUSY : DN_DROP;
                        end
                    end
                end
                DN_BUSY, DN_DROP: begin
                    if (dn_hs) begin
                        dn_cnt_q <= dn_cnt_q - LEN_ONE;
                        if (dn_cnt_q == LEN_ONE) begin
                            dn_state_q <= DN_IDLE;
                        end
                    end
                end
                default: dn_state_q <= DN_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wormhole_concentrator_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_wormhole_concentrator_rr
// Purpose  : Self-checking bench for bp_me_wormhole_concentrator_rr. Packets
//            are queued per link. A packet-level reference model predicts
//            the grant, the routing, drops and the error flag every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_me_wormhole_concentrator_rr;

    localparam int W  = 64;
    localparam int CW = 7;
    localparam int LW = 4;
    localparam int IW = 4;
    localparam int N  = 4;

    logic             clk = 1'b0;
    logic             reset_n_i;
    logic [N-1:0]     links_v_i;
    logic [N*W-1:0]   links_data_i;
    logic [N-1:0]     links_ready_and_o;
    logic [N-1:0]     links_v_o;
    logic [N*W-1:0]   links_data_o;
    logic [N-1:0]     links_ready_and_i;
    logic             conc_v_o;
    logic [W-1:0]     conc_data_o;
    logic             conc_ready_and_i;
    logic             conc_v_i;
    logic [W-1:0]     conc_data_i;
    logic             conc_ready_and_o;
    logic             err_o;

    always #5 clk = ~clk;

    bp_me_wormhole_concentrator_rr #(
        .flit_width_p (W),
        .cord_width_p (CW),
        .len_width_p  (LW),
        .cid_width_p  (IW),
        .num_in_p     (N)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n_i),
        .links_v_i         (links_v_i),
        .links_data_i      (links_data_i),
        .links_ready_and_o (links_ready_and_o),
        .links_v_o         (links_v_o),
        .links_data_o      (links_data_o),
        .links_ready_and_i (links_ready_and_i),
        .conc_v_o          (conc_v_o),
        .conc_data_o       (conc_data_o),
        .conc_ready_and_i  (conc_ready_and_i),
        .conc_v_i          (conc_v_i),
        .conc_data_i       (conc_data_i),
        .conc_ready_and_o  (conc_ready_and_o),
        .err_o             (err_o)
    );

    // Pending flits per tile link, plus the downstream stream.
    logic [W-1:0] upq [N][$];
    logic [W-1:0] dnq [$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    // owner   : link that holds the upstream wormhole, or -1 when free.
    // d_mode  : -1 when free, 0..N-1 when routing a packet, N when dropping.
    int m_owner, m_left, m_rr;
    int d_mode, d_left;
    bit m_err;
    int grants [N];

    bit refill_en;
    int up_maxlen;
    int up_pfill;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_hdr(input int len, input int cid);
        logic [W-1:0] h;
        h = {$urandom, $urandom};
        h[CW +: LW] = LW'(len);
        h[CW+LW +: IW] = IW'(cid);
        return h;
    endfunction

    task automatic push_up(input int k, input int len);
        upq[k].push_back(mk_hdr(len, $urandom_range(15, 0)));
        for (int i = 0; i < len; i++) upq[k].push_back({$urandom, $urandom});
    endtask

    task automatic push_dn(input int cid, input int len);
        dnq.push_back(mk_hdr(len, cid));
        for (int i = 0; i < len; i++) dnq.push_back({$urandom, $urandom});
    endtask

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_rr = 0;
        d_mode  = -1; d_left = 0; m_err = 1'b0;
    endtask

    // One clock cycle: drive the inputs just after the edge. Mid-cycle,
    // compare against the model, then advance the model for the coming edge.
    task automatic cycle(input int p_uv, input int p_crdy, input int p_dv, input int p_lrdy);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_lv;
        logic [W-1:0] f;
        int           sel, dest, len;
        bit           exp_cv, drop, exp_crdy;

        @(posedge clk); #1;
        if (refill_en) begin
            for (int k = 0; k < N; k++)
                if (upq[k].size() == 0 && $urandom_range(99, 0) < up_pfill)
                    push_up(k, $urandom_range(up_maxlen, 0));
            if (dnq.size() < 2) push_dn($urandom_range(4, 0), $urandom_range(3, 0));
        end
        for (int k = 0; k < N; k++) begin
            v[k] = (upq[k].size() > 0) && ($urandom_range(99, 0) < p_uv);
            links_data_i[k*W +: W] = (upq[k].size() > 0) ? upq[k][0] : '0;
            links_ready_and_i[k] = ($urandom_range(99, 0) < p_lrdy);
        end
        links_v_i        = v;
        conc_ready_and_i = ($urandom_range(99, 0) < p_crdy);
        conc_v_i         = (dnq.size() > 0) && ($urandom_range(99, 0) < p_dv);
        conc_data_i      = (dnq.size() > 0) ? dnq[0] : {$urandom, $urandom};
        #3;

        // Upstream: a locked owner keeps the link; otherwise the first valid
        // link from the round-robin pointer wins.
        sel = -1;
        if (m_owner >= 0) begin
            sel = m_owner;
            exp_cv = v[sel];
        end else begin
            for (int i = 0; i < N; i++)
                if (sel < 0 && v[(m_rr + i) % N]) sel = (m_rr + i) % N;
            exp_cv = (sel >= 0);
        end
        exp_rdy = '0;
        if (sel >= 0) exp_rdy[sel] = conc_ready_and_i;
        check("conc_v", conc_v_o, exp_cv);
        check("up_ready", links_ready_and_o & v, exp_rdy & v);
        if (exp_cv) check("conc_data", conc_data_o, upq[sel][0]);
        if (exp_cv && conc_ready_and_i) begin
            f = upq[sel].pop_front();
            grants[sel]++;
            if (m_owner < 0) begin
                m_rr = (sel + 1) % N;
                len  = int'(f[CW +: LW]);
                if (len != 0) begin
                    m_owner = sel;
                    m_left  = len;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end

        // Downstream
        if (d_mode < 0) begin
            dest = int'(conc_data_i[CW+LW +: IW]);
            drop = (dest >= N);
        end else begin
            dest = d_mode;
            drop = (d_mode == N);
        end
        exp_lv = '0;
        if (!drop && conc_v_i) exp_lv[dest] = 1'b1;
        if (drop) exp_crdy = 1'b1;
        else      exp_crdy = links_ready_and_i[dest];
        check("dn_v", links_v_o, exp_lv);
        check("dn_ready", conc_ready_and_o, exp_crdy);
        for (int k = 0; k < N; k++) check("dn_data", links_data_o[k*W +: W], conc_data_i);
        check("err", err_o, m_err);
        if (conc_v_i && exp_crdy) begin
            f = dnq.pop_front();
            if (d_mode < 0) begin
                if (drop) m_err = 1'b1;
                len = int'(f[CW +: LW]);
                if (len != 0) begin
                    d_mode = drop ? N : dest;
                    d_left = len;
                end
            end else begin
                d_left--;
                if (d_left == 0) d_mode = -1;
            end
        end
    endtask

    // Reset asserted in the middle of a cycle with every input active. All
    // handshake outputs and err_o must drop at once, with no clock edge.
    task automatic reset_pulse();
        @(posedge clk); #1;
        reset_n_i         = 1'b0;
        links_v_i         = '1;
        links_ready_and_i = '1;
        conc_v_i          = 1'b1;
        conc_ready_and_i  = 1'b1;
        #1;
        check("rst_conc_v", conc_v_o, 1'b0);
        check("rst_up_ready", links_ready_and_o, '0);
        check("rst_dn_v", links_v_o, '0);
        check("rst_dn_ready", conc_ready_and_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        @(posedge clk); #1;
        check("rst_err_hold", err_o, 1'b0);
        reset_n_i = 1'b1;
        links_v_i = '0;
        conc_v_i  = 1'b0;
        for (int k = 0; k < N; k++) upq[k].delete();
        dnq.delete();
        model_reset();
    endtask

    initial begin
        int total;
        reset_n_i         = 1'b0;
        links_v_i         = '1;
        links_data_i      = '0;
        links_ready_and_i = '1;
        conc_v_i          = 1'b1;
        conc_data_i       = '0;
        conc_ready_and_i  = 1'b1;
        refill_en = 1'b0;
        up_maxlen = 0;
        up_pfill  = 0;
        for (int k = 0; k < N; k++) grants[k] = 0;
        model_reset();

        // Reset state with all inputs active
        @(posedge clk); @(posedge clk); #1;
        check("init_conc_v", conc_v_o, 1'b0);
        check("init_up_ready", links_ready_and_o, '0);
        check("init_dn_v", links_v_o, '0);
        check("init_dn_ready", conc_ready_and_o, 1'b0);
        check("init_err", err_o, 1'b0);
        reset_n_i = 1'b1;
        links_v_i = '0;
        conc_v_i  = 1'b0;

        // A lone valid on link 2 is forwarded in the same cycle
        push_up(2, 0);
        cycle(100, 100, 0, 100);
        cycle(100, 100, 0, 100);

        // Contention: links 0 and 1 each offer a 3-flit packet
        push_up(0, 2);
        push_up(1, 2);
        for (int c = 0; c < 8; c++) cycle(100, 100, 0, 100);
        check("contention_rr", m_rr, 2);

        // Directed downstream: a good cid, then a bad cid
        push_dn(2, 1);
        push_dn(5, 2);
        for (int c = 0; c < 6; c++) cycle(0, 100, 100, 100);
        check("drop_err", err_o, 1'b1);

        // Fairness: every link always valid with single-flit packets
        for (int k = 0; k < N; k++) grants[k] = 0;
        refill_en = 1'b1;
        up_maxlen = 0;
        up_pfill  = 100;
        total     = 0;
        for (int c = 0; c < 1000 && total < 400; c++) begin
            cycle(100, 100, 70, 60);
            total = 0;
            for (int k = 0; k < N; k++) total += grants[k];
        end
        for (int k = 0; k < N; k++) check($sformatf("fair_link%0d", k), grants[k], 100);

        // Random traffic with valid gaps and backpressure on both paths
        up_maxlen = 4;
        up_pfill  = 30;
        for (int c = 0; c < 2500; c++) cycle(70, 60, 70, 60);
        for (int c = 0; c < 300; c++)  cycle(60, $urandom_range(1, 0) * 100, 60, 60);

        // Reset in the middle of a packet: the next flit is a fresh header
        refill_en = 1'b0;
        reset_pulse();
        push_up(0, 4);
        cycle(100, 100, 0, 100);
        cycle(100, 100, 0, 100);
        reset_pulse();
        push_up(1, 0);
        push_up(3, 0);
        for (int c = 0; c < 4; c++) cycle(100, 100, 0, 100);
        check("post_rst_rr", m_rr, 0);

        // More random traffic after the reset
        refill_en = 1'b1;
        for (int c = 0; c < 500; c++) cycle(70, 70, 70, 70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
